// File: rtl/irq_controller_if.sv
// CPU handshake, peripheral flag and register-bus signals of the interrupt controller.
// slave is the controller's view; master is the CPU/peripheral/bus side.
interface irq_controller_if #(
    parameter int N_IRQ = 4
);
    localparam int VW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0] irq_in;
    logic [N_IRQ-1:0] irq_clr;
    logic             irq_req;
    logic [VW-1:0]    irq_vector;
    logic             irq_ack;
    logic             iret;
    logic [15:0]      address;
    logic [7:0]       din;
    logic             w_en;
    logic             r_en;
    logic [7:0]       dout;

    modport slave (
        input  irq_in, irq_ack, iret,
        input  address, din, w_en, r_en,
        output irq_clr, irq_req, irq_vector, dout
    );

    modport master (
        output irq_in, irq_ack, iret,
        output address, din, w_en, r_en,
        input  irq_clr, irq_req, irq_vector, dout
    );
endinterface

// File: rtl/irq_controller.sv
// Prioritising interrupt scheduler: masks, arbitrates, latches one source,
// hands it to the CPU and blocks further requests until return-from-interrupt.
module irq_controller #(
    parameter int          N_IRQ     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h1F00
) (
    input  logic           clk,
    input  logic           reset,
    irq_controller_if.slave bus
);
    localparam int VW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic             gie_q, gie_d;
    logic             req_q, req_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [N_IRQ-1:0] clr_q, clr_d;
    logic [7:0]       dout_q, dout_d;

    logic [15:0]      offset;
    logic             hit;
    logic [1:0]       reg_sel;
    logic             wr_mask, wr_ctrl;
    logic [N_IRQ-1:0] eligible;
    logic [VW-1:0]    winner;
    logic [N_IRQ-1:0] clr_sel;
    logic             in_service;
    logic [7:0]       status;
    logic [7:0]       rdata;
    logic             unused_din;

    assign offset     = bus.address - BASE_ADDR;
    assign hit        = (offset[15:2] == 14'd0);
    assign reg_sel    = offset[1:0];
    assign wr_mask    = bus.w_en && hit && (reg_sel == 2'd0);
    assign wr_ctrl    = bus.w_en && hit && (reg_sel == 2'd3);
    assign unused_din = ^bus.din[7:1];

    assign in_service = (state_q == SERVICE);
    assign eligible   = bus.irq_in & mask_q & {N_IRQ{gie_q}};

    always_comb begin
        mask_d = wr_mask ? bus.din[N_IRQ-1:0] : mask_q;
        gie_d  = wr_ctrl ? bus.din[0] : gie_q;
    end

    // Scan from the top so the lowest set index wins.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = VW'(i);
        end
    end

    always_comb begin
        clr_sel        = '0;
        clr_sel[vec_q] = 1'b1;
    end

    // Withdrawal looks at the GIE value being written this cycle; ack still wins.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        clr_d   = '0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    vec_d   = winner;
                    req_d   = 1'b1;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (bus.irq_ack) begin
                    req_d   = 1'b0;
                    clr_d   = clr_sel;
                    state_d = SERVICE;
                end else if (!gie_d) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.iret) state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        status         = '0;
        status[7]      = in_service;
        status[6]      = req_q;
        status[VW-1:0] = vec_q;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata[N_IRQ-1:0] = mask_q;
            2'd1: rdata[N_IRQ-1:0] = bus.irq_in;
            2'd2: rdata = status;
            2'd3: rdata[0] = gie_q;
            default: rdata = '0;
        endcase
        dout_d = (bus.r_en && hit) ? rdata : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            gie_q   <= 1'b0;
            req_q   <= 1'b0;
            vec_q   <= '0;
            clr_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            gie_q   <= gie_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            clr_q   <= clr_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.irq_req    = req_q;
    assign bus.irq_vector = vec_q;
    assign bus.irq_clr    = clr_q;
    assign bus.dout       = dout_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: arbitration, handshake, withdrawal,
// register access and asynchronous reset.
module tb_irq_controller;
    localparam logic [15:0] BASE = 16'h1F00;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    irq_controller_if #(.N_IRQ(4)) bus ();

    irq_controller #(
        .N_IRQ    (4),
        .BASE_ADDR(BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] data);
        bus.address = BASE + 16'(off);
        bus.din     = data;
        bus.w_en    = 1'b1;
        step();
        bus.w_en    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        bus.address = addr;
        bus.r_en    = 1'b1;
        step();
        bus.r_en    = 1'b0;
        data        = bus.dout;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if (bus.irq_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.irq_req);
        else passed++;
        total++;
        if (bus.irq_clr !== 4'b0) $display("FAIL reset_clr got %b want 0000", bus.irq_clr);
        else passed++;
        total++;
        if (bus.irq_vector !== 2'd0) $display("FAIL reset_vec got %0d want 0", bus.irq_vector);
        else passed++;
        total++;
        if (bus.dout !== 8'h00) $display("FAIL reset_dout got %h want 00", bus.dout);
        else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        bus_write(2'd0, 8'h0F);
        bus_write(2'd3, 8'h01);
        bus_read(BASE, d);
        total++;
        if (d !== 8'h0F) $display("FAIL mask_rb got %h want 0f", d);
        else passed++;
        bus.irq_in = 4'b0100;
        step();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vector !== 2'd2)
            $display("FAIL basic_req got req=%b vec=%0d want req=1 vec=2", bus.irq_req, bus.irq_vector);
        else passed++;
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_clr !== 4'b0100)
            $display("FAIL basic_ack got req=%b clr=%b want req=0 clr=0100", bus.irq_req, bus.irq_clr);
        else passed++;
        step();
        total++;
        if (bus.irq_clr !== 4'b0000) $display("FAIL basic_clr_len got %b want 0000", bus.irq_clr);
        else passed++;
        bus_read(BASE + 16'd2, d);
        total++;
        if (d !== 8'h82) $display("FAIL basic_status got %h want 82", d);
        else passed++;
        bus.irq_in = 4'b0000;
        bus.iret   = 1'b1;
        step();
        bus.iret   = 1'b0;
    endtask

    task automatic test_simultaneous();
        bus.irq_in = 4'b1010;
        step();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vector !== 2'd1)
            $display("FAIL simul_req got req=%b vec=%0d want req=1 vec=1", bus.irq_req, bus.irq_vector);
        else passed++;
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        total++;
        if (bus.irq_clr !== 4'b0010) $display("FAIL simul_clr got %b want 0010", bus.irq_clr);
        else passed++;
        bus.irq_in = 4'b1000;
        step();
        total++;
        if (bus.irq_req !== 1'b0) $display("FAIL simul_svc_req got %b want 0", bus.irq_req);
        else passed++;
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        total++;
        if (bus.irq_req !== 1'b0) $display("FAIL iret_edge1 got %b want 0", bus.irq_req);
        else passed++;
        step();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vector !== 2'd3)
            $display("FAIL iret_edge2 got req=%b vec=%0d want req=1 vec=3", bus.irq_req, bus.irq_vector);
        else passed++;
    endtask

    task automatic test_no_preempt();
        logic [7:0] d;
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        total++;
        if (bus.irq_clr !== 4'b1000) $display("FAIL svc3_clr got %b want 1000", bus.irq_clr);
        else passed++;
        bus.irq_in = 4'b0001;
        step();
        step();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_clr !== 4'b0000)
            $display("FAIL preempt got req=%b clr=%b want req=0 clr=0000", bus.irq_req, bus.irq_clr);
        else passed++;
        bus_read(BASE + 16'd2, d);
        total++;
        if (d !== 8'h83) $display("FAIL preempt_status got %h want 83", d);
        else passed++;
        bus.iret = 1'b1;
        step();
        bus.iret = 1'b0;
        step();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vector !== 2'd0)
            $display("FAIL after_iret got req=%b vec=%0d want req=1 vec=0", bus.irq_req, bus.irq_vector);
        else passed++;
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        bus.irq_in  = 4'b0000;
        bus.iret    = 1'b1;
        step();
        bus.iret    = 1'b0;
    endtask

    task automatic test_withdraw();
        logic [7:0] d;
        bus.irq_in = 4'b0100;
        step();
        total++;
        if (bus.irq_req !== 1'b1) $display("FAIL wd_req got %b want 1", bus.irq_req);
        else passed++;
        bus_write(2'd3, 8'h00);
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_clr !== 4'b0000)
            $display("FAIL wd_drop got req=%b clr=%b want req=0 clr=0000", bus.irq_req, bus.irq_clr);
        else passed++;
        bus_read(BASE + 16'd2, d);
        total++;
        if (d !== 8'h02 || bus.irq_clr !== 4'b0000)
            $display("FAIL wd_status got %h clr=%b want 02 clr=0000", d, bus.irq_clr);
        else passed++;
        bus_write(2'd3, 8'h01);
        step();
        total++;
        if (bus.irq_req !== 1'b1) $display("FAIL wd_rereq got %b want 1", bus.irq_req);
        else passed++;
        bus.address = BASE + 16'd3;
        bus.din     = 8'h00;
        bus.w_en    = 1'b1;
        bus.irq_ack = 1'b1;
        step();
        bus.w_en    = 1'b0;
        bus.irq_ack = 1'b0;
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_clr !== 4'b0100)
            $display("FAIL ack_wins got req=%b clr=%b want req=0 clr=0100", bus.irq_req, bus.irq_clr);
        else passed++;
        bus_read(BASE + 16'd2, d);
        total++;
        if (d !== 8'h82) $display("FAIL ack_wins_status got %h want 82", d);
        else passed++;
        bus.irq_in = 4'b0000;
        bus.iret   = 1'b1;
        step();
        bus.iret   = 1'b0;
    endtask

    task automatic test_mask_regs();
        logic [7:0] d;
        bus_write(2'd0, 8'h01);
        bus_write(2'd3, 8'h01);
        bus.irq_in = 4'b0010;
        step();
        step();
        total++;
        if (bus.irq_req !== 1'b0) $display("FAIL masked_req got %b want 0", bus.irq_req);
        else passed++;
        bus_read(BASE + 16'd1, d);
        total++;
        if (d !== 8'h02) $display("FAIL pending got %h want 02", d);
        else passed++;
        bus_read(BASE, d);
        total++;
        if (d !== 8'h01) $display("FAIL mask01_rb got %h want 01", d);
        else passed++;
        bus_read(BASE + 16'd4, d);
        total++;
        if (d !== 8'h00) $display("FAIL unmapped_hi got %h want 00", d);
        else passed++;
        bus.address = BASE;
        step();
        total++;
        if (bus.dout !== 8'h00) $display("FAIL no_read_dout got %h want 00", bus.dout);
        else passed++;
        bus.irq_in = 4'b0000;
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        bus_write(2'd0, 8'h0F);
        bus_write(2'd3, 8'h01);
        bus.irq_in = 4'b0001;
        step();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_clr !== 4'b0000)
            $display("FAIL rst_svc got req=%b clr=%b want req=0 clr=0000", bus.irq_req, bus.irq_clr);
        else passed++;
        #1;
        reset = 1'b0;
        step();
        bus_read(BASE, d);
        total++;
        if (d !== 8'h00) $display("FAIL rst_mask got %h want 00", d);
        else passed++;
        bus_read(BASE + 16'd3, d);
        total++;
        if (d !== 8'h00) $display("FAIL rst_gie got %h want 00", d);
        else passed++;
        bus_write(2'd0, 8'h0F);
        bus_write(2'd3, 8'h01);
        bus.irq_in = 4'b0100;
        step();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_vector !== 2'd2)
            $display("FAIL rst_pre_req got req=%b vec=%0d want req=1 vec=2", bus.irq_req, bus.irq_vector);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.irq_req !== 1'b0 || bus.irq_vector !== 2'd0 || bus.irq_clr !== 4'b0000)
            $display("FAIL rst_req got req=%b vec=%0d clr=%b want 0 0 0000",
                     bus.irq_req, bus.irq_vector, bus.irq_clr);
        else passed++;
        #1;
        reset = 1'b0;
        step();
        step();
        total++;
        if (bus.irq_req !== 1'b0) $display("FAIL rst_no_rereq got %b want 0", bus.irq_req);
        else passed++;
        bus.irq_in = 4'b0000;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        reset       = 1'b1;
        bus.irq_in  = '0;
        bus.irq_ack = 1'b0;
        bus.iret    = 1'b0;
        bus.address = '0;
        bus.din     = '0;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        test_reset();
        test_basic();
        test_simultaneous();
        test_no_preempt();
        test_withdraw();
        test_mask_regs();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritising interrupt scheduler between the peripheral interrupt flags (video blanking, timer top/match0/match1) and the CPU interrupt entry logic.
- Masks, arbitrates and latches one winning source, presents its vector to the CPU and holds it until acknowledged.
- Issues the one-cycle flag-clear pulse back to the owning peripheral, then blocks further requests until the CPU signals return-from-interrupt.
- Configured through four byte registers on the data-memory/IO bus.

Parameters:
- N_IRQ, 4, number of interrupt sources; vector width is clog2(N_IRQ).
- BASE_ADDR, 16'h1F00, bus address of register offset 0; offsets 0-3 are decoded.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- irq_in  in  N_IRQ  level interrupt flags from peripherals; bit 0 has highest priority
- irq_clr  out  N_IRQ  one-hot, one-cycle clear pulse to the serviced source
- irq_req  out  1  interrupt request to the CPU
- irq_vector  out  2  index of the latched source; valid while irq_req or in_service
- irq_ack  in  1  CPU accepts the request (single-cycle pulse)
- iret  in  1  CPU finished the handler (single-cycle pulse)
- address  in  16  data/IO bus address
- din  in  8  bus write data
- w_en  in  1  bus write strobe
- r_en  in  1  bus read strobe
- dout  out  8  bus read data

Behaviour:
- Registers (offset from BASE_ADDR):
  - 0 MASK: R/W, bits [N_IRQ-1:0]; upper bits read 0.
  - 1 PENDING: RO, raw irq_in.
  - 2 STATUS: RO; bit7 = in_service, bit6 = irq_req, bits[1:0] = irq_vector.
  - 3 CTRL: R/W; bit0 = GIE.
- Writes take effect at the edge where w_en=1 and the address matches. Reads are registered: dout is valid the cycle after r_en. dout is 0 when the previous cycle had no matching read.
- Reset values: MASK=0, GIE=0, irq_req=0, irq_vector=0, irq_clr=0, dout=0, state=IDLE.
- eligible = irq_in & MASK & {N_IRQ{GIE}}. Winner = lowest set index of eligible.
- FSM states:
  - IDLE: if eligible != 0 at an edge, latch the winner into irq_vector, set irq_req=1 and go to REQUEST. Latency from irq_in rising to irq_req high is exactly one edge.
  - REQUEST: irq_req and irq_vector are held stable.
    - irq_ack=1: irq_req->0, irq_clr[vector]=1 for exactly that next cycle, go to SERVICE.
    - GIE=0 (written or already low) with no ack: withdraw; irq_req->0, go to IDLE, no clr pulse.
    - Ack and GIE clear in the same cycle: ack wins.
    - MASK changes and new higher-priority arrivals do not alter the latched vector.
  - SERVICE: in_service=1, irq_vector held. No preemption; irq_ack is ignored. iret=1 -> IDLE. Re-arbitration happens in IDLE, so the earliest new irq_req is two edges after iret.
- iret outside SERVICE is ignored.
- A source that remains asserted after its clr pulse is re-requested after iret. The peripheral owns the flag semantics.
- irq_clr is always one-hot or zero and never asserts outside the REQUEST->SERVICE transition.
- Asynchronous reset at any point aborts any request or service immediately. No clr pulse is generated.

Test Plan:
- Reset, write MASK=0x0F, CTRL=0x01, pulse irq_in=0b0100 -> irq_req=1 one edge later, vector=2. irq_ack -> irq_clr=0b0100 for exactly 1 cycle, STATUS reads 0x82.
- irq_in=0b1010 asserted simultaneously -> vector=1. After ack and iret with bit1 cleared -> second request with vector=3, arriving 2 edges after iret.
- In SERVICE (vector=3), raise irq_in[0] -> no irq_req until iret, then vector=0. No preemption.
- In REQUEST, write CTRL=0x00 -> irq_req falls next edge, irq_clr stays 0. Same-cycle irq_ack plus GIE write -> ack honoured, clr pulse issued.
- MASK=0x01 with irq_in=0b0010 -> no request. PENDING reads 0x02 one cycle after r_en. MASK reads back 0x01. Unmapped address reads 0.
- Assert reset while in SERVICE and while in REQUEST -> irq_req=0, irq_clr=0, MASK=0, GIE=0 immediately, without waiting for a clock edge.
